fifo_drain_ctrl: RTL

- Read-side controller for the team's synchronous FIFO. It issues read_enable to the FIFO and captures fifo_data_out, which is valid one cycle after read_enable.
- Captured words go into an internal 3-entry output buffer, which is presented to a downstream valid/ready consumer.
- Bursts start only once the FIFO has built up data (not almost_empty) or a start timeout expires, so trickle traffic is not drained word by word.

---
 rtl/fifo_drain_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the synchronous FIFO.
// It waits for the FIFO to fill (or for a start timeout) before it bursts,
// then streams words into a 3-entry output buffer with a valid/ready port.
module fifo_drain_ctrl #(
   parameter int TAMANO_DATOS  = 10,
   parameter int START_TIMEOUT = 8,
   parameter int CONT_BITS     = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    fifo_empty,
   input  logic                    fifo_almost_empty,
   input  logic                    fifo_error,
   input  logic [TAMANO_DATOS-1:0] fifo_data_out,
   output logic                    read_enable,
   output logic [TAMANO_DATOS-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CONT_BITS-1:0]    word_count,
   output logic                    underflow
);

   localparam int TW = $clog2(START_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_FILL, DRAIN} state_t;

   state_t                  state, state_nxt;
   logic [TW-1:0]           timer, timer_nxt;
   logic [1:0]              occ;
   logic                    in_flight;
   logic                    pop;
   logic [TAMANO_DATOS-1:0] fbuf [3];

   // A read only goes out if its word is guaranteed a buffer slot when it
   // lands next cycle; out_ready is deliberately not looked at. Reads in a
   // reset cycle are suppressed since their data would be thrown away.
   always_comb begin
      read_enable = !reset && (state == DRAIN) && !fifo_empty &&
                    (({1'b0, occ} + {2'b00, in_flight}) < 3'd3);
   end

   // Output port: head of the buffer, valid whenever something is held.
   always_comb begin
      out_valid = (occ != 2'd0);
      out_data  = fbuf[0];
      pop       = out_valid && out_ready;
   end

   // Next-state logic: hold off bursts until the FIFO has built up data
   // or it has sat non-empty for START_TIMEOUT cycles.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = WAIT_FILL;
               timer_nxt = '0;
            end
         end
         WAIT_FILL: begin
            if (!fifo_almost_empty) begin
               state_nxt = DRAIN;
            end else if (!fifo_empty) begin
               if (timer == TW'(START_TIMEOUT - 1)) state_nxt = DRAIN;
               else                                 timer_nxt = timer + 1'b1;
            end else begin
               timer_nxt = '0;
            end
         end
         DRAIN: begin
            // Leave only after the last outstanding word has landed.
            if (fifo_empty && !in_flight) begin
               state_nxt = WAIT_FILL;
               timer_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!enable) state_nxt = IDLE;
   end

   // State and timer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Buffer, occupancy and counters. The buffer is a shift queue with the
   // head in slot 0; only occupied slots shift so the head keeps its last
   // value when the buffer runs empty. A capture lands behind whatever is
   // left after this cycle's pop, preserving order.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ        <= 2'd0;
         in_flight  <= 1'b0;
         word_count <= '0;
         underflow  <= 1'b0;
         for (int i = 0; i < 3; i++) fbuf[i] <= '0;
      end else begin
         in_flight <= read_enable;
         occ       <= occ + {1'b0, in_flight} - {1'b0, pop};
         if (fifo_error) underflow <= 1'b1;
         if (pop) word_count <= word_count + 1'b1;
         for (int i = 0; i < 2; i++) begin
            if (pop && (occ > 2'(i + 1))) fbuf[i] <= fbuf[i + 1];
         end
         if (in_flight) fbuf[occ - {1'b0, pop}] <= fifo_data_out;
      end
   end

endmodule
